// File: rtl/frame_plotter.sv
// frame_plotter: snapshots a 16x32 playfield bitmap on start and streams it
// to the VGA adapter one pixel per clock. Each cell becomes a 2x2 block at a
// fixed screen origin. Dirty-only mode skips cells that are unchanged since
// the last completed frame.
module frame_plotter #(
    parameter int         X0         = 64,
    parameter int         Y0         = 28,
    parameter logic [2:0] FG         = 3'b010,
    parameter logic [2:0] BG         = 3'b001,
    parameter bit         DIRTY_ONLY = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] display,
    output logic [7:0]   x,
    output logic [6:0]   y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLOT = 1'b1
    } state_t;

    state_t       state_q;
    logic [511:0] snap_q;        // frame being drawn, frozen at start
    logic [511:0] prev_q;        // last completed frame
    logic         prev_valid_q;
    logic [8:0]   cell_q;        // {cx, cy}: equals the bitmap index 32*cx+cy
    logic [1:0]   sub_q;         // sub-pixel s: bit0 = sx, bit1 = sy
    logic         fin_q;         // last cell visited; next edge closes the frame
    logic [7:0]   x_q;
    logic [6:0]   y_q;
    logic [2:0]   colour_q;
    logic         plot_q;
    logic         busy_q;
    logic         done_q;

    logic [7:0]   x_d;
    logic [6:0]   y_d;
    logic [2:0]   colour_d;
    logic         draw_d;
    logic         last_d;

    // Pixel coordinates, colour and draw/skip decision for the current cell.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        x_d      = 8'(X0) + {3'b000, cell_q[8:5], 1'b0} + {7'b0, sub_q[0]};
        y_d      = 7'(Y0) + {1'b0, cell_q[4:0], 1'b0} + {6'b0, sub_q[1]};
        colour_d = snap_q[cell_q] ? FG : BG;
        draw_d   = !DIRTY_ONLY || !prev_valid_q || (snap_q[cell_q] != prev_q[cell_q]);
        last_d   = (cell_q == 9'd511) && (!draw_d || sub_q == 2'd3);
    end

    // Control FSM with registered outputs; frame bookkeeping on completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            // NOTE: the bitmaps are cleared on reset because a cleared,
            // invalid history is what forces the next frame to a full redraw.
            snap_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            cell_q       <= '0;
            sub_q        <= '0;
            fin_q        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, independent of statement order.
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    plot_q <= 1'b0;
                    if (start) begin
                        snap_q  <= display;
                        cell_q  <= '0;
                        sub_q   <= '0;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= PLOT;
                    end
                end
                PLOT: begin
                    if (fin_q) begin
                        state_q      <= IDLE;
                        fin_q        <= 1'b0;
                        plot_q       <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        prev_q       <= snap_q;
                        prev_valid_q <= 1'b1;
                    end else begin
                        plot_q <= draw_d;
                        if (draw_d) begin
                            x_q      <= x_d;
                            y_q      <= y_d;
                            colour_q <= colour_d;
                        end
                        if (draw_d && sub_q != 2'd3) begin
                            sub_q <= sub_q + 2'd1;
                        end else begin
                            sub_q  <= '0;
                            cell_q <= cell_q + 9'd1;
                        end
                        if (last_d) begin
                            fin_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_frame_plotter.sv
// Bench for frame_plotter: one full-redraw instance and one dirty-only
// instance, checked every cycle against a frame-level expectation queue.
module tb_frame_plotter;

    localparam int         X0 = 64;
    localparam int         Y0 = 28;
    localparam logic [2:0] FG = 3'b010;
    localparam logic [2:0] BG = 3'b001;

    typedef struct packed {
        logic       plot;
        logic       busy;
        logic       done;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic [511:0] display = '0;
    logic [7:0]   x0, x1;
    logic [6:0]   y0, y1;
    logic [2:0]   colour0, colour1;
    logic         plot0, plot1, busy0, busy1, done0, done1;

    frame_plotter #(.DIRTY_ONLY(1'b0)) u_full (
        .clock(clk), .reset(rst), .start(start0), .display(display),
        .x(x0), .y(y0), .colour(colour0), .plot(plot0), .busy(busy0), .done(done0)
    );

    frame_plotter #(.DIRTY_ONLY(1'b1)) u_dirty (
        .clock(clk), .reset(rst), .start(start1), .display(display),
        .x(x1), .y(y1), .colour(colour1), .plot(plot1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // Reference model state and observation counters.
    exp_t         exp0[$];
    exp_t         exp1[$];
    logic [511:0] prev_m[2];
    bit           pv_m[2];
    int           cyc;
    int           start_cyc[2], done_cyc[2], plots[2], fgs[2], fg_box[2];
    bit           done_seen[2];
    logic [7:0]   first_x[2], last_x[2];
    logic [6:0]   first_y[2], last_y[2];
    logic [14:0]  pix_log[$];
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int k, input exp_t e);
        if (k == 0) exp0.push_back(e);
        else        exp1.push_back(e);
    endtask

    // Expected output sequence of one frame, cycle by cycle after the start edge.
    task automatic build_frame(input int k, input logic [511:0] snap, input bit dirty);
        exp_t e;
        bit   draw;
        e = '0; e.busy = 1'b1;
        push(k, e);
        for (int cx = 0; cx < 16; cx++) begin
            for (int cy = 0; cy < 32; cy++) begin
                draw = !dirty || !pv_m[k] || (snap[32*cx+cy] != prev_m[k][32*cx+cy]);
                if (draw) begin
                    for (int sy = 0; sy < 2; sy++) begin
                        for (int sx = 0; sx < 2; sx++) begin
                            e = '0;
                            e.plot   = 1'b1;
                            e.busy   = 1'b1;
                            e.x      = 8'(X0 + 2*cx + sx);
                            e.y      = 7'(Y0 + 2*cy + sy);
                            e.colour = snap[32*cx+cy] ? FG : BG;
                            push(k, e);
                        end
                    end
                end else begin
                    e = '0; e.busy = 1'b1;
                    push(k, e);
                end
            end
        end
        e = '0; e.done = 1'b1;
        push(k, e);
        prev_m[k] = snap;
        pv_m[k]   = 1'b1;
    endtask

    task automatic accept(input int k);
        start_cyc[k] = cyc;
        plots[k] = 0; fgs[k] = 0; fg_box[k] = 0;
        done_seen[k] = 1'b0;
        if (k == 1) pix_log.delete();
        build_frame(k, display, k == 1);
    endtask

    // Model: a start is taken whenever no frame is outstanding in the model.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp0.delete(); exp1.delete();
            prev_m[0] = '0; prev_m[1] = '0;
            pv_m[0] = 1'b0; pv_m[1] = 1'b0;
        end else begin
            cyc++;
            if (start0 && exp0.size() == 0) accept(0);
            if (start1 && exp1.size() == 0) accept(1);
        end
    end

    task automatic compare(input int k, input logic p, input logic b, input logic d,
                           input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
        exp_t e;
        e = '0;
        if (k == 0 && exp0.size() > 0) e = exp0.pop_front();
        else if (k == 1 && exp1.size() > 0) e = exp1.pop_front();
        check($sformatf("plot%0d", k), int'(p), int'(e.plot));
        check($sformatf("busy%0d", k), int'(b), int'(e.busy));
        check($sformatf("done%0d", k), int'(d), int'(e.done));
        if (e.plot) begin
            check($sformatf("x%0d", k), int'(xx), int'(e.x));
            check($sformatf("y%0d", k), int'(yy), int'(e.y));
            check($sformatf("colour%0d", k), int'(cc), int'(e.colour));
        end
        if (p) begin
            plots[k]++;
            if (plots[k] == 1) begin first_x[k] = xx; first_y[k] = yy; end
            last_x[k] = xx; last_y[k] = yy;
            if (cc == FG) begin
                fgs[k]++;
                if ((xx == 8'd70 || xx == 8'd71) && (yy == 7'd38 || yy == 7'd39)) fg_box[k]++;
            end
            if (k == 1) pix_log.push_back({xx, yy});
        end
        if (d) begin
            done_seen[k] = 1'b1;
            done_cyc[k]  = cyc;
        end
    endtask

    // Single compare process: every cycle, both instances, away from the edge.
    always @(negedge clk) begin
        compare(0, plot0, busy0, done0, x0, y0, colour0);
        compare(1, plot1, busy1, done1, x1, y1, colour1);
    end

    function automatic logic [511:0] rand_bits();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic do_start(input int k);
        @(posedge clk); #2;
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit);
        int n;
        n = 0;
        while (!done_seen[k] && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("done_reached%0d", k), int'(done_seen[k]), 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] snap_saved;
        int           n;
        int           last_done;

        // Reset state
        repeat (3) @(posedge clk); #2;
        check("rst_x",      int'(x0), 0);
        check("rst_y",      int'(y0), 0);
        check("rst_colour", int'(colour0), 0);
        check("rst_plot",   int'(plot0), 0);
        check("rst_busy",   int'(busy1), 0);
        check("rst_done",   int'(done1), 0);
        rst = 1'b0;

        // Full redraw of an empty field
        display = '0;
        do_start(0);
        wait_done(0, 2200);
        check("full_plots",   plots[0], 2048);
        check("full_fg",      fgs[0], 0);
        check("full_first_x", int'(first_x[0]), 64);
        check("full_first_y", int'(first_y[0]), 28);
        check("full_last_x",  int'(last_x[0]), 95);
        check("full_last_y",  int'(last_y[0]), 91);
        check("full_done_at", done_cyc[0] - start_cyc[0], 2049);

        // Single set cell at (3,5)
        display = '0;
        display[32*3+5] = 1'b1;
        do_start(0);
        wait_done(0, 2200);
        check("single_plots",  plots[0], 2048);
        check("single_fg",     fgs[0], 4);
        check("single_fg_box", fg_box[0], 4);

        // Dirty mode: full first frame, then one changed cell
        display = '0;
        do_start(1);
        wait_done(1, 2200);
        check("dirty_first_plots", plots[1], 2048);
        display[32*3+5] = 1'b1;
        do_start(1);
        wait_done(1, 700);
        check("dirty_plots",   plots[1], 4);
        check("dirty_log_len", pix_log.size(), 4);
        if (pix_log.size() == 4) begin
            check("dirty_pix0", int'(pix_log[0]), int'({8'd70, 7'd38}));
            check("dirty_pix1", int'(pix_log[1]), int'({8'd71, 7'd38}));
            check("dirty_pix2", int'(pix_log[2]), int'({8'd70, 7'd39}));
            check("dirty_pix3", int'(pix_log[3]), int'({8'd71, 7'd39}));
        end
        check("dirty_done_at", done_cyc[1] - start_cyc[1], 516);

        // Start re-pulsed while busy is ignored
        display = rand_bits();
        do_start(0);
        repeat (99) @(posedge clk);
        #2 start0 = 1'b1;
        @(posedge clk); #2 start0 = 1'b0;
        wait_done(0, 2200);
        check("busy_start_done_at", done_cyc[0] - start_cyc[0], 2049);
        repeat (10) @(posedge clk); #2;
        check("busy_start_no_rerun", int'(busy0), 0);

        // Reset in the middle of a frame
        display = ~display;
        do_start(1);
        n = 0;
        while (plots[1] < 700 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check("mid_reached_700", int'(plots[1] >= 700), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_plot", int'(plot1), 0);
        check("mid_rst_busy", int'(busy1), 0);
        check("mid_rst_done", int'(done1), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        display = '0;
        do_start(1);
        wait_done(1, 2200);
        check("post_rst_full_plots", plots[1], 2048);

        // Snapshot isolation: display toggles every cycle during the frame
        display = rand_bits();
        snap_saved = display;
        do_start(0);
        n = 0;
        while (!done_seen[0] && n < 2200) begin
            @(posedge clk); #2 display = ~display;
            n++;
        end
        wait_done(0, 10);
        check("iso_fg", fgs[0], 4 * $countones(snap_saved));

        // Randomized dirty frames, back to back, alongside a full-redraw frame
        display = prev_m[1];
        #0;
        start0 = 1'b1;
        do_start(1);
        for (int i = 0; i < 6; i++) begin
            wait_done(1, 2200);
            last_done = done_cyc[1];
            for (int j = 0; j < int'($urandom_range(6, 0)); j++)
                display[$urandom_range(511, 0)] ^= 1'b1;
            start1 = 1'b1;
            @(posedge clk); #2 start1 = 1'b0;
            check("b2b_gap", start_cyc[1], last_done + 1);
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(50, 1)) @(posedge clk);
                #2 start1 = 1'b1;
                @(posedge clk); #2 start1 = 1'b0;
            end
        end
        wait_done(1, 2200);
        wait_done(0, 2200);
        repeat (5) @(posedge clk); #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
